line_tap_buffer_ram: RTL and testbench

//  Parametrised multi-line pixel delay buffer for the LK optical-flow front end (Ix/Iy/It windows).
//  - Successor to the fixed 800-point, 4-line shift-tap buffer.
//  - Adds a generic width, line length and tap count, frame-start resynchronisation,

---
 rtl/line_tap_buffer_ram_pkg.sv | 18 +
 rtl/line_tap_buffer_ram_ram.sv | 31 +++
 rtl/line_tap_buffer_ram.sv | 135 +++++++++++++
 tb/tb_line_tap_buffer_ram.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/line_tap_buffer_ram_pkg.sv
// Shared definitions for the multi-line pixel delay buffer.
//   H_ACTIVE      : horizontal active width of the video timing, default line length
//   DEF_DATA_W    : default bits per sample
//   DEF_NUM_TAPS  : default number of delayed lines
//   pos_step_e    : per-cycle action on the column/row position counters
package line_tap_buffer_ram_pkg;

  localparam int unsigned H_ACTIVE     = 800;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_TAPS = 4;

  typedef enum logic [1:0] {
    POS_HOLD    = 2'd0,
    POS_ADVANCE = 2'd1,
    POS_WRAP    = 2'd2
  } pos_step_e;

endpackage

// File: rtl/line_tap_buffer_ram_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// Written so that synthesis maps it onto block RAM.
//   clk      : clock, all activity on the rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address, sampled every cycle
//   o_q      : read data, one cycle after i_raddr
module simple_dp_ram #(
  parameter int unsigned DATA_W_RAM = 32,
  parameter int unsigned DEPTH      = 800,
  localparam int unsigned ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_W_RAM-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_W_RAM-1:0] o_q
);

  logic [DATA_W_RAM-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_q <= r_mem[i_raddr];
  end

endmodule

// File: rtl/line_tap_buffer_ram.sv
// Multi-line pixel delay buffer feeding the window-sum logic of the optical-flow
// front end. Each RAM word c holds column c of the last NUM_TAPS lines (line 0 in
// the low DATA_W bits is the newest); each accepted sample pushes itself into the
// bottom of its column word and the oldest line falls off the top.
//   CLOCK65    : pixel clock
//   RESETN     : asynchronous active-low reset
//   sof        : start of frame, clears the position counters
//   shift_en   : accept din this cycle
//   din        : input sample
//   cur_out    : last accepted sample
//   taps       : tap k = sample from (k+1)*LINE_LEN shifts earlier
//   out_valid  : cur_out/taps updated this cycle
//   taps_ready : all NUM_TAPS lines filled since the last sof/reset
//   col_idx    : column of cur_out
//   row_idx    : row of cur_out, saturating at NUM_TAPS
//   line_end   : out_valid for the last column of a line
module line_tap_buffer_ram
  import line_tap_buffer_ram_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned LINE_LEN = H_ACTIVE,
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  localparam int unsigned COL_W   = $clog2(LINE_LEN),
  localparam int unsigned ROW_W   = $clog2(NUM_TAPS + 1),
  localparam int unsigned TAPS_W  = NUM_TAPS * DATA_W
) (
  input  logic              CLOCK65,
  input  logic              RESETN,
  input  logic              sof,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] cur_out,
  output logic [TAPS_W-1:0] taps,
  output logic              out_valid,
  output logic              taps_ready,
  output logic [COL_W-1:0]  col_idx,
  output logic [ROW_W-1:0]  row_idx,
  output logic              line_end
);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  w_base_col;
  logic [ROW_W-1:0]  w_base_row;
  logic [COL_W-1:0]  w_next_col;
  logic [ROW_W-1:0]  w_next_row;
  logic              w_wrap;
  logic              w_row_full;
  pos_step_e         w_step;
  logic [TAPS_W-1:0] w_q;
  logic [TAPS_W-1:0] w_wdata;

  // Position of the sample being accepted this cycle: sof forces column 0 / row 0
  // immediately so a sample arriving with sof lands in column 0.
  always_comb begin
    w_base_col = sof ? '0 : r_col;
    w_base_row = sof ? '0 : r_row;
    w_wrap     = (w_base_col == COL_W'(LINE_LEN - 1));
    w_row_full = (w_base_row == ROW_W'(NUM_TAPS));
  end

  always_comb begin
    w_step = POS_HOLD;
    if (shift_en) begin
      w_step = w_wrap ? POS_WRAP : POS_ADVANCE;
    end
  end

  always_comb begin
    w_next_col = w_base_col;
    w_next_row = w_base_row;
    case (w_step)
      POS_ADVANCE: w_next_col = w_base_col + COL_W'(1);
      POS_WRAP: begin
        w_next_col = '0;
        if (!w_row_full) begin
          w_next_row = w_base_row + ROW_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Newest line enters at the bottom; the oldest line is dropped off the top.
  if (NUM_TAPS > 1) begin : g_multi_tap
    always_comb w_wdata = {w_q[TAPS_W-DATA_W-1:0], din};
  end else begin : g_single_tap
    always_comb w_wdata = din;
  end

  // The read address is the column the following cycle will work on, so the
  // registered read output always holds mem[r_col] when a shift arrives. After
  // sof with a shift the next column is 1, not 0. Write and read addresses only
  // coincide when no write happens (LINE_LEN >= 2).
  simple_dp_ram #(
    .DATA_W_RAM (TAPS_W),
    .DEPTH      (LINE_LEN)
  ) u_ram (
    .clk     (CLOCK65),
    .i_we    (shift_en),
    .i_waddr (w_base_col),
    .i_wdata (w_wdata),
    .i_raddr (w_next_col),
    .o_q     (w_q)
  );

  always_ff @(posedge CLOCK65 or negedge RESETN) begin
    if (!RESETN) begin
      r_col      <= '0;
      r_row      <= '0;
      cur_out    <= '0;
      taps       <= '0;
      out_valid  <= 1'b0;
      taps_ready <= 1'b0;
      col_idx    <= '0;
      row_idx    <= '0;
      line_end   <= 1'b0;
    end else begin
      r_col     <= w_next_col;
      r_row     <= w_next_row;
      out_valid <= shift_en;
      line_end  <= shift_en && w_wrap;
      if (shift_en) begin
        cur_out    <= din;
        taps       <= w_q;
        col_idx    <= w_base_col;
        row_idx    <= w_base_row;
        taps_ready <= w_row_full;
      end else if (sof) begin
        taps_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_tap_buffer_ram.sv
module tb_line_tap_buffer_ram;

  logic        clk;
  logic        RESETN;
  logic        sof;
  logic        shift_en;
  logic [31:0] din;

  // Instance A: LINE_LEN=8, NUM_TAPS=4, 32-bit
  logic [31:0]  a_cur;
  logic [127:0] a_taps;
  logic         a_valid, a_ready, a_le;
  logic [2:0]   a_col;
  logic [2:0]   a_row;
  // Instance B: defaults 800/4/32
  logic [31:0]  b_cur;
  logic [127:0] b_taps;
  logic         b_valid, b_ready, b_le;
  logic [9:0]   b_col;
  logic [2:0]   b_row;
  // Instance C: LINE_LEN=2, NUM_TAPS=3, 16-bit
  logic [15:0]  c_cur;
  logic [47:0]  c_taps;
  logic         c_valid, c_ready, c_le;
  logic [0:0]   c_col;
  logic [1:0]   c_row;

  line_tap_buffer_ram #(.DATA_W(32), .LINE_LEN(8), .NUM_TAPS(4)) u_dut_a (
    .CLOCK65(clk), .RESETN(RESETN), .sof(sof), .shift_en(shift_en), .din(din),
    .cur_out(a_cur), .taps(a_taps), .out_valid(a_valid), .taps_ready(a_ready),
    .col_idx(a_col), .row_idx(a_row), .line_end(a_le));

  line_tap_buffer_ram u_dut_b (
    .CLOCK65(clk), .RESETN(RESETN), .sof(sof), .shift_en(shift_en), .din(din),
    .cur_out(b_cur), .taps(b_taps), .out_valid(b_valid), .taps_ready(b_ready),
    .col_idx(b_col), .row_idx(b_row), .line_end(b_le));

  line_tap_buffer_ram #(.DATA_W(16), .LINE_LEN(2), .NUM_TAPS(3)) u_dut_c (
    .CLOCK65(clk), .RESETN(RESETN), .sof(sof), .shift_en(shift_en), .din(din[15:0]),
    .cur_out(c_cur), .taps(c_taps), .out_valid(c_valid), .taps_ready(c_ready),
    .col_idx(c_col), .row_idx(c_row), .line_end(c_le));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: history of accepted samples since the last sof/reset.
  string        nm   [3] = '{"A", "B", "C"};
  int unsigned  mL   [3] = '{8, 800, 2};
  int unsigned  mT   [3] = '{4, 4, 3};
  int unsigned  mW   [3] = '{32, 32, 16};
  logic [31:0]  mMsk [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0]  hist [3][$];

  logic         e_valid [3];
  logic [31:0]  e_cur   [3];
  logic [127:0] e_taps  [3];
  logic         e_tchk  [3];
  logic         e_ready [3];
  int unsigned  e_col   [3];
  int unsigned  e_row   [3];
  logic         e_le    [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i].delete();
      e_valid[i] = 1'b0; e_cur[i] = '0; e_taps[i] = '0; e_tchk[i] = 1'b1;
      e_ready[i] = 1'b0; e_col[i] = 0;  e_row[i] = 0;   e_le[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i, input logic s, input logic sh, input logic [31:0] d);
    int unsigned n, line;
    logic [31:0] v;
    e_valid[i] = sh;
    e_le[i]    = 1'b0;
    if (s) begin
      hist[i].delete();
      e_ready[i] = 1'b0;
    end
    if (sh) begin
      n    = hist[i].size();
      line = n / mL[i];
      v    = d & mMsk[i];
      e_cur[i]   = v;
      e_col[i]   = n % mL[i];
      e_row[i]   = (line > mT[i]) ? mT[i] : line;
      e_le[i]    = (e_col[i] == mL[i] - 1);
      e_ready[i] = (line >= mT[i]);
      e_tchk[i]  = e_ready[i];
      if (e_ready[i]) begin
        e_taps[i] = '0;
        for (int unsigned k = 0; k < mT[i]; k++)
          e_taps[i] = e_taps[i] | (128'(hist[i][n - (k + 1) * mL[i]]) << (k * mW[i]));
      end
      hist[i].push_back(v);
    end
  endtask

  task automatic check_one(input int i, input logic v, input logic [31:0] cur, input logic [127:0] tp,
                           input logic rdy, input int unsigned col, input int unsigned row, input logic le);
    check({nm[i], ".out_valid"},  128'(v),   128'(e_valid[i]));
    check({nm[i], ".cur_out"},    128'(cur), 128'(e_cur[i]));
    check({nm[i], ".col_idx"},    128'(col), 128'(e_col[i]));
    check({nm[i], ".row_idx"},    128'(row), 128'(e_row[i]));
    check({nm[i], ".line_end"},   128'(le),  128'(e_le[i]));
    check({nm[i], ".taps_ready"}, 128'(rdy), 128'(e_ready[i]));
    if (e_tchk[i]) check({nm[i], ".taps"}, tp, e_taps[i]);
  endtask

  task automatic check_all();
    check_one(0, a_valid, a_cur, a_taps, a_ready, 32'(a_col), 32'(a_row), a_le);
    check_one(1, b_valid, b_cur, b_taps, b_ready, 32'(b_col), 32'(b_row), b_le);
    check_one(2, c_valid, 32'(c_cur), 128'(c_taps), c_ready, 32'(c_col), 32'(c_row), c_le);
  endtask

  // Called at posedge+1: apply inputs, let one edge pass, update model, check.
  task automatic cycle(input logic s, input logic sh, input logic [31:0] d);
    sof = s; shift_en = sh; din = d;
    @(posedge clk);
    if (RESETN) for (int i = 0; i < 3; i++) model_edge(i, s, sh, d);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int unsigned ncyc);
    RESETN = 1'b0; sof = 1'b0; shift_en = 1'b1; din = 32'd5;
    model_reset();
    #1;
    check_all();
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      check_all();
    end
    RESETN = 1'b1;
  endtask

  int unsigned b_le_cnt;

  initial begin
    RESETN = 1'b0; sof = 1'b0; shift_en = 1'b0; din = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset with shift_en held high, then incrementing din every cycle.
    do_reset(3);
    for (int unsigned i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, i);
      if (i == 0) begin
        check("t1.a_cur", 128'(a_cur), 128'd0);
        check("t1.a_col", 128'(a_col), 128'd0);
        check("t1.a_valid", 128'(a_valid), 128'd1);
      end
      if (i == 31) check("t2.ready_low", 128'(a_ready), 128'd0);
      if (i == 32) begin
        check("t2.ready_high", 128'(a_ready), 128'd1);
        check("t2.taps32", a_taps, {32'd0, 32'd8, 32'd16, 32'd24});
      end
      if (i == 39) check("t2.taps39", a_taps, {32'd7, 32'd15, 32'd23, 32'd31});
    end

    // sof mid-line: abandon at row 2 column 5.
    cycle(1'b1, 1'b0, 32'd0);
    check("t4.ready_on_sof", 128'(a_ready), 128'd0);
    for (int unsigned j = 0; j < 21; j++) cycle(1'b0, 1'b1, 32'd100 + j);
    cycle(1'b1, 1'b0, 32'd0);
    for (int unsigned j = 0; j < 33; j++) begin
      cycle(1'b0, 1'b1, 32'd200 + j);
      if (j == 0) begin
        check("t4.col0", 128'(a_col), 128'd0);
        check("t4.row0", 128'(a_row), 128'd0);
      end
      if (j == 31) check("t4.still_low", 128'(a_ready), 128'd0);
    end

    // sof together with shift_en.
    cycle(1'b1, 1'b1, 32'hAB);
    check("t5.cur", 128'(a_cur), 128'hAB);
    check("t5.col", 128'(a_col), 128'd0);
    cycle(1'b0, 1'b1, 32'hAC);
    check("t5.col1", 128'(a_col), 128'd1);

    // Default geometry, shift every second cycle.
    cycle(1'b1, 1'b0, 32'd0);
    b_le_cnt = 0;
    for (int unsigned j = 0; j < 3300; j++) begin
      cycle(1'b0, 1'b1, j);
      if (b_le) b_le_cnt++;
      if (j == 3200) check("t3.taps3200", b_taps, {32'd0, 32'd800, 32'd1600, 32'd2400});
      cycle(1'b0, 1'b0, $urandom);
    end
    check("t3.line_end_cnt", 128'(b_le_cnt), 128'd4);

    // Random gaps, occasional sof, one reset in the middle.
    for (int unsigned j = 0; j < 4000; j++) begin
      if (j == 2000) do_reset(2);
      cycle(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
